// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1: two-port single-outstanding arbiter onto one shared memory port with response watchdog
module mem_arbiter_2to1 #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_p0_req_valid,
    input  logic              i_p0_req_we,
    input  logic [ADDR_W-1:0] i_p0_req_addr,
    input  logic [XLEN-1:0]   i_p0_req_wdata,
    input  logic [XLEN/8-1:0] i_p0_req_wstrb,
    output logic              o_p0_resp_valid,
    output logic [XLEN-1:0]   o_p0_resp_rdata,
    output logic              o_p0_resp_err,
    input  logic              i_p1_req_valid,
    input  logic              i_p1_req_we,
    input  logic [ADDR_W-1:0] i_p1_req_addr,
    input  logic [XLEN-1:0]   i_p1_req_wdata,
    input  logic [XLEN/8-1:0] i_p1_req_wstrb,
    output logic              o_p1_resp_valid,
    output logic [XLEN-1:0]   o_p1_resp_rdata,
    output logic              o_p1_resp_err,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic              o_mem_req_we,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    output logic [XLEN-1:0]   o_mem_req_wdata,
    output logic [XLEN/8-1:0] o_mem_req_wstrb,
    input  logic              i_mem_resp_valid,
    input  logic [XLEN-1:0]   i_mem_resp_rdata,
    output logic              o_busy,
    output logic              o_spurious_resp,
    output logic              o_timeout
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic            grant;
    logic            last_grant;
    logic [CW-1:0]   cnt;
    logic            pick;
    logic            fire;
    logic [XLEN-1:0] rd;

    always_comb begin
        pick = (i_p0_req_valid && i_p1_req_valid) ? ((ROUND_ROBIN != 0) ? ~last_grant : 1'b1) : i_p1_req_valid;
        fire = (TIMEOUT_CYCLES != 0) && (cnt == TLAST);
        rd   = i_mem_resp_valid ? i_mem_resp_rdata : '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            grant           <= 1'b0;
            last_grant      <= 1'b1;
            cnt             <= '0;
            o_p0_resp_valid <= 1'b0;
            o_p0_resp_rdata <= '0;
            o_p0_resp_err   <= 1'b0;
            o_p1_resp_valid <= 1'b0;
            o_p1_resp_rdata <= '0;
            o_p1_resp_err   <= 1'b0;
            o_mem_req_valid <= 1'b0;
            o_mem_req_we    <= 1'b0;
            o_mem_req_addr  <= '0;
            o_mem_req_wdata <= '0;
            o_mem_req_wstrb <= '0;
            o_busy          <= 1'b0;
            o_spurious_resp <= 1'b0;
            o_timeout       <= 1'b0;
        end else begin
            // response outputs are nonzero only during the single RESP cycle
            o_p0_resp_valid <= 1'b0;
            o_p0_resp_rdata <= '0;
            o_p0_resp_err   <= 1'b0;
            o_p1_resp_valid <= 1'b0;
            o_p1_resp_rdata <= '0;
            o_p1_resp_err   <= 1'b0;
            if (i_mem_resp_valid && state != WAIT)
                o_spurious_resp <= 1'b1;
            case (state)
                IDLE: if (i_p0_req_valid || i_p1_req_valid) begin
                    grant           <= pick;
                    last_grant      <= pick;
                    o_mem_req_we    <= pick ? i_p1_req_we    : i_p0_req_we;
                    o_mem_req_addr  <= pick ? i_p1_req_addr  : i_p0_req_addr;
                    o_mem_req_wdata <= pick ? i_p1_req_wdata : i_p0_req_wdata;
                    o_mem_req_wstrb <= pick ? i_p1_req_wstrb : i_p0_req_wstrb;
                    o_mem_req_valid <= 1'b1;
                    o_busy          <= 1'b1;
                    state           <= ISSUE;
                end
                ISSUE: if (i_mem_req_ready) begin
                    o_mem_req_valid <= 1'b0;
                    cnt             <= '0;
                    state           <= WAIT;
                end
                WAIT: begin
                    if (cnt != '1)
                        cnt <= cnt + 1'b1;
                    // a response in the timeout cycle wins over the error
                    if (i_mem_resp_valid || fire) begin
                        o_p0_resp_valid <= ~grant;
                        o_p1_resp_valid <= grant;
                        o_p0_resp_rdata <= grant ? '0 : rd;
                        o_p1_resp_rdata <= grant ? rd : '0;
                        o_p0_resp_err   <= ~grant & ~i_mem_resp_valid;
                        o_p1_resp_err   <= grant & ~i_mem_resp_valid;
                        if (!i_mem_resp_valid)
                            o_timeout <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter_2to1.md
Name: mem_arbiter_2to1

Overview:
- Two-requestor, single-outstanding memory arbiter between the CPU front/back end and one shared memory port.
- Port 0 is the instruction fetch path (cpu_ifetch_unit side); port 1 is the data path (cpu_memory_unit side).
- Downstream is a single memory model or controller, replacing the separate instruction and data memories with one unified memory.
- Registered round-robin or fixed-priority grant, request capture, response routing and a response-timeout watchdog.

Parameters:
- XLEN, 32, data width.
- ADDR_W, 32, address width.
- ROUND_ROBIN, 1: 1 = alternate on contention; 0 = port 1 (data) always wins.
- TIMEOUT_CYCLES, 256: maximum WAIT cycles before an error response; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_pN_req_valid  in  1  request, N = 0/1; held high until that port's resp pulse.
- i_pN_req_we  in  1  1 = write.
- i_pN_req_addr  in  ADDR_W  byte address.
- i_pN_req_wdata  in  XLEN  write data.
- i_pN_req_wstrb  in  XLEN/8  byte enables.
- o_pN_resp_valid  out  1  one-cycle response pulse.
- o_pN_resp_rdata  out  XLEN  read data.
- o_pN_resp_err  out  1  timeout error, qualified by resp_valid.
- o_mem_req_valid  out  1  request to memory.
- i_mem_req_ready  in  1  memory accepts the request this cycle.
- o_mem_req_we / o_mem_req_addr / o_mem_req_wdata / o_mem_req_wstrb  out  1/ADDR_W/XLEN/XLEN/8  captured request.
- i_mem_resp_valid  in  1  memory response, for both reads and writes.
- i_mem_resp_rdata  in  XLEN  response data.
- o_busy  out  1  state != IDLE.
- o_spurious_resp  out  1  sticky: memory response received outside WAIT.
- o_timeout  out  1  sticky: watchdog fired.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Round-robin pointer last_grant = 1, so port 0 wins the first tie.
  - Timeout counter 0.
  - Sticky flags cleared; they are cleared only by reset.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If any i_pN_req_valid is high, select the winner.
  - Single requester: that port wins.
  - Both requesting, ROUND_ROBIN=1: winner is the port != last_grant.
  - Both requesting, ROUND_ROBIN=0: port 1 wins.
  - Capture we/addr/wdata/wstrb, set grant and last_grant, go to ISSUE.
- ISSUE:
  - o_mem_req_valid = 1 with the captured fields.
  - Stay while i_mem_req_ready = 0.
  - On ready, go to WAIT and clear the counter; o_mem_req_valid drops the following cycle.
- WAIT:
  - Counter increments every cycle.
  - On i_mem_resp_valid: capture rdata, err = 0, go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1: rdata = 0, err = 1, set o_timeout, go to RESP.
  - A response and the timeout in the same cycle: the response wins, err = 0.
- RESP:
  - The granted port's o_pN_resp_valid = 1 for exactly this cycle, with rdata/err; the other port's outputs stay 0.
  - Next state IDLE. The requester drops valid at the end of RESP, so IDLE never re-grants a completed request.
- Latency, ready = 1 and memory response 1 cycle after accept:
  - Request seen at edge T.
  - ISSUE during T+1.
  - WAIT during T+2; response at T+2.
  - RESP during T+3.
  - Minimum 4 cycles per transaction.
- i_mem_resp_valid in IDLE, ISSUE or RESP: ignored and o_spurious_resp set. A late response after a timeout falls in this case.
- i_mem_resp_valid is not accepted in the same cycle as i_mem_req_ready; the memory contract is a response at least 1 cycle after accept.
- The requester must hold its request fields stable until its response. The arbiter uses only the captured copy, so later changes are harmless.
- Reset mid-operation:
  - Immediate return to IDLE with outputs cleared; no response pulse is emitted for the aborted request.
  - A memory response arriving after reset release, while in IDLE, sets o_spurious_resp.
- Counter width: clog2(TIMEOUT_CYCLES + 1); it saturates and never wraps.

Test Plan:
1. Port 0 read addr 0x100, memory returns 0xDEADBEEF one cycle after accept, ready = 1 -> o_mem_req_valid one cycle with addr 0x100; o_p0_resp_valid pulses 4 cycles after request with rdata 0xDEADBEEF, err 0; o_p1_resp_valid stays 0.
2. Both ports request in the same cycle (p0 read 0x0, p1 write 0x200 data 0x12345678 wstrb 0xF), ROUND_ROBIN=1, ports re-request immediately -> grants p0, p1, p0, p1 in order; the p1 write appears on the memory port with exact fields. Repeat with ROUND_ROBIN=0 -> p1 always granted first.
3. i_mem_req_ready held 0 for 5 cycles -> o_mem_req_valid high and fields stable for 6 cycles; exactly one accept; one response pulse.
4. TIMEOUT_CYCLES=8, memory never responds -> response pulse with err 1, rdata 0, o_timeout = 1; a memory response 3 cycles later sets o_spurious_resp and produces no resp pulse.
5. Assert i_reset asynchronously mid-WAIT, between clock edges -> o_busy and all outputs 0 immediately; no resp pulse; after release a new p1 request completes normally.
6. Response arrives in the same cycle the timeout would fire (TIMEOUT_CYCLES=4, response on the 4th WAIT cycle) -> err 0, rdata from memory, o_timeout stays 0.
